// File: rtl/mat_pkg.sv
// Shared definitions for the LED-matrix frame controller and scanner.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mat_pkg;

    localparam int ROW_IDX_W        = 3;
    localparam int ROW_W            = 8;
    localparam int NUM_ROWS         = 8;
    // 8 rows x 5001 clocks per row; the scanner uses the same figure
    localparam int FRAME_CYCLES_DEF = 40008;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_ACK     = 2'd2
    } state_t;

endpackage

// File: rtl/mat_frame_timer.sv
// Free-running frame counter; flags the last cycle of each frame and pulses a tick after it.
// Latency: o_boundary is combinational from the counter, o_frame_tick is registered one edge later.
// Backpressure: none, runs continuously.
// Ports: i_clk, i_rst_n (async active-low), o_boundary (fcnt == FRAME_CYCLES-1),
//        o_frame_tick (high while fcnt == 0 after a wrap, never right after reset).
module mat_frame_timer
    import mat_pkg::*;
#(
    parameter int FRAME_CYCLES = FRAME_CYCLES_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_boundary,
    output logic o_frame_tick
);

    localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

    logic [CW-1:0] r_fcnt;
    logic          r_tick;
    logic          w_boundary;

    assign w_boundary   = (r_fcnt == CW'(FRAME_CYCLES - 1));
    assign o_boundary   = w_boundary;
    assign o_frame_tick = r_tick;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fcnt <= '0;
            r_tick <= 1'b0;
        end else begin
            r_fcnt <= w_boundary ? '0 : r_fcnt + 1'b1;
            r_tick <= w_boundary;
        end
    end

endmodule

// File: rtl/mat_frame_ctrl.sv
// Double-buffered row-pattern store; back buffer copied to the displayed front buffer on a frame boundary.
// Latency: write lands 1 edge after wr_en; swap lands on the next boundary edge, swap_ack one cycle after.
// Backpressure: wr_ready low while a swap is pending or being acknowledged; writes then dropped.
// Ports: clock, rst_n (async active-low), wr_en/wr_row/wr_data/wr_ready (back-buffer write),
//        swap_req/swap_ack (level request, one-cycle ack), blink, frame_tick, m0..m7 (to scanner).
// Optional blink masking is compiled in with `define MAT_BLINK_EN.
module mat_frame_ctrl
    import mat_pkg::*;
#(
    parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
    parameter int BLINK_FRAMES = 25
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [ROW_IDX_W-1:0] wr_row,
    input  logic [ROW_W-1:0]     wr_data,
    output logic                 wr_ready,
    input  logic                 swap_req,
    output logic                 swap_ack,
    input  logic                 blink,
    output logic                 frame_tick,
    output logic [ROW_W-1:0]     m0,
    output logic [ROW_W-1:0]     m1,
    output logic [ROW_W-1:0]     m2,
    output logic [ROW_W-1:0]     m3,
    output logic [ROW_W-1:0]     m4,
    output logic [ROW_W-1:0]     m5,
    output logic [ROW_W-1:0]     m6,
    output logic [ROW_W-1:0]     m7
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_boundary;
    logic             w_tick;
    logic             w_do_swap;
    logic             w_blank;
    logic [ROW_W-1:0] r_back  [NUM_ROWS];
    logic [ROW_W-1:0] r_front [NUM_ROWS];

    mat_frame_timer #(
        .FRAME_CYCLES (FRAME_CYCLES)
    ) u_timer (
        .i_clk        (clock),
        .i_rst_n      (rst_n),
        .o_boundary   (w_boundary),
        .o_frame_tick (w_tick)
    );

    assign frame_tick = w_tick;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A request first seen in a boundary cycle only reaches PENDING after that
    // boundary, so it waits a full frame for the next one.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (swap_req)   w_state_nxt = ST_PENDING;
            ST_PENDING: if (w_boundary) w_state_nxt = ST_ACK;
            ST_ACK:                     w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ready  = (r_state == ST_IDLE);
        swap_ack  = (r_state == ST_ACK);
        w_do_swap = (r_state == ST_PENDING) && w_boundary;
    end

    // Writes and the copy never coincide: writes need IDLE, the copy needs PENDING.
    // The back buffer is kept across swaps so only changed rows need rewriting.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ROWS; i++) begin
                r_back[i]  <= '0;
                r_front[i] <= '0;
            end
        end else begin
            if (wr_en && wr_ready) begin
                r_back[wr_row] <= wr_data;
            end
            if (w_do_swap) begin
                for (int i = 0; i < NUM_ROWS; i++) begin
                    r_front[i] <= r_back[i];
                end
            end
        end
    end

`ifdef MAT_BLINK_EN
    localparam int BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BCW-1:0] r_bcnt;
    logic           r_phase_on;

    // Phase flips after every BLINK_FRAMES frame ticks; it only gates the
    // outputs, the front buffer itself is untouched.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_bcnt     <= '0;
            r_phase_on <= 1'b1;
        end else if (w_tick) begin
            if (r_bcnt == BCW'(BLINK_FRAMES - 1)) begin
                r_bcnt     <= '0;
                r_phase_on <= ~r_phase_on;
            end else begin
                r_bcnt <= r_bcnt + 1'b1;
            end
        end
    end

    assign w_blank = blink & ~r_phase_on;
`else
    localparam int unused_blink_frames = BLINK_FRAMES;
    logic w_unused_blink;

    assign w_unused_blink = blink;
    assign w_blank        = 1'b0;
`endif

    assign m0 = w_blank ? '0 : r_front[0];
    assign m1 = w_blank ? '0 : r_front[1];
    assign m2 = w_blank ? '0 : r_front[2];
    assign m3 = w_blank ? '0 : r_front[3];
    assign m4 = w_blank ? '0 : r_front[4];
    assign m5 = w_blank ? '0 : r_front[5];
    assign m6 = w_blank ? '0 : r_front[6];
    assign m7 = w_blank ? '0 : r_front[7];

endmodule
